// File: rtl/elevator_scheduler_if.sv
// elevator_scheduler_if: call/status bundle between the elevator scheduler and its user.
// Carries i_estop only when EMERGENCY_STOP_EN is defined.
interface elevator_scheduler_if #(
    parameter int FLOORS  = 4,
    parameter int FLOOR_W = 2
);
    logic [FLOORS-1:0]  i_call;
    logic [FLOOR_W-1:0] o_floor;
    logic               o_moving_up;
    logic               o_moving_down;
    logic               o_door_open;
    logic               o_green;
    logic               o_red;
    logic [FLOORS-1:0]  o_pending;
`ifdef EMERGENCY_STOP_EN
    logic               i_estop;
    modport master (output i_call, output i_estop, input o_floor, input o_moving_up,
                    input o_moving_down, input o_door_open, input o_green, input o_red, input o_pending);
    modport slave  (input i_call, input i_estop, output o_floor, output o_moving_up,
                    output o_moving_down, output o_door_open, output o_green, output o_red, output o_pending);
`else
    modport master (output i_call, input o_floor, input o_moving_up,
                    input o_moving_down, input o_door_open, input o_green, input o_red, input o_pending);
    modport slave  (input i_call, output o_floor, output o_moving_up,
                    output o_moving_down, output o_door_open, output o_green, output o_red, output o_pending);
`endif
endinterface

// File: rtl/elevator_scheduler.sv
// elevator_scheduler: SCAN call scheduler owning floor position, motion and door commands.
// Defining EMERGENCY_STOP_EN adds i_estop, which freezes counters and departures.
module elevator_scheduler #(
    parameter int FLOORS     = 4,
    parameter int FLOOR_W    = 2,
    parameter int TRAVEL_CYC = 4,
    parameter int DOOR_CYC   = 3
) (
    input logic                  clk,
    input logic                  reset,
    elevator_scheduler_if.slave  bus
);
    localparam int CMAX = (TRAVEL_CYC > DOOR_CYC) ? TRAVEL_CYC : DOOR_CYC;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR} state_t;

    state_t             r_state, w_nxt;
    logic [FLOOR_W-1:0] r_floor, w_floor_nxt;
    logic [FLOORS-1:0]  r_pending, w_pend_nxt;
    logic               r_dir_up, w_dir_nxt;
    logic [CW-1:0]      r_cnt, w_cnt_nxt;
    logic               r_moving_up, r_moving_down, r_door_open, r_green;
    logic               w_estop;
    logic [FLOORS-1:0]  w_req, w_here, w_below_m, w_above_m;
    logic               w_at, w_above, w_below;

`ifdef EMERGENCY_STOP_EN
    assign w_estop = bus.i_estop;
`else
    assign w_estop = 1'b0;
`endif

    assign w_req     = r_pending | bus.i_call;
    assign w_here    = FLOORS'(1) << r_floor;
    assign w_below_m = w_here - FLOORS'(1);
    assign w_above_m = ~(w_below_m | w_here);
    assign w_at      = |(w_req & w_here);
    assign w_above   = |(w_req & w_above_m);
    assign w_below   = |(w_req & w_below_m);

    // Calls always land in pending; only the bit of the floor whose door is open is dropped.
    always_comb begin
        w_nxt       = r_state;
        w_cnt_nxt   = r_cnt;
        w_floor_nxt = r_floor;
        w_dir_nxt   = r_dir_up;
        w_pend_nxt  = w_req;
        case (r_state)
            IDLE: begin
                if (!w_estop && w_at) begin
                    w_nxt      = DOOR;
                    w_cnt_nxt  = '0;
                    w_pend_nxt = w_req & ~w_here;
                end else if (!w_estop && w_above && (r_dir_up || !w_below)) begin
                    w_nxt     = MOVE_UP;
                    w_cnt_nxt = '0;
                    w_dir_nxt = 1'b1;
                end else if (!w_estop && w_below) begin
                    w_nxt     = MOVE_DOWN;
                    w_cnt_nxt = '0;
                    w_dir_nxt = 1'b0;
                end
            end
            MOVE_UP, MOVE_DOWN: begin
                if (!w_estop && r_cnt == CW'(TRAVEL_CYC - 1)) begin
                    w_nxt       = IDLE;
                    w_cnt_nxt   = '0;
                    w_floor_nxt = (r_state == MOVE_UP) ? r_floor + FLOOR_W'(1) : r_floor - FLOOR_W'(1);
                end else if (!w_estop) begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            DOOR: begin
                w_pend_nxt = w_req & ~w_here;
                if (!w_estop && w_at) begin
                    w_cnt_nxt = '0;
                end else if (!w_estop && r_cnt == CW'(DOOR_CYC - 1)) begin
                    w_nxt     = IDLE;
                    w_cnt_nxt = '0;
                end else if (!w_estop) begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_floor       <= '0;
            r_pending     <= '0;
            r_dir_up      <= 1'b1;
            r_cnt         <= '0;
            r_moving_up   <= 1'b0;
            r_moving_down <= 1'b0;
            r_door_open   <= 1'b0;
            r_green       <= 1'b0;
        end else begin
            r_state       <= w_nxt;
            r_floor       <= w_floor_nxt;
            r_pending     <= w_pend_nxt;
            r_dir_up      <= w_dir_nxt;
            r_cnt         <= w_cnt_nxt;
            r_moving_up   <= w_nxt == MOVE_UP;
            r_moving_down <= w_nxt == MOVE_DOWN;
            r_door_open   <= w_nxt == DOOR;
            r_green       <= (w_nxt == DOOR) && !w_estop;
        end
    end

    assign bus.o_floor       = r_floor;
    assign bus.o_pending     = r_pending;
    assign bus.o_moving_up   = r_moving_up;
    assign bus.o_moving_down = r_moving_down;
    assign bus.o_door_open   = r_door_open;
    assign bus.o_green       = r_green;
    assign bus.o_red         = ~r_green;
endmodule

// File: tb/tb_elevator_scheduler.sv
// tb_elevator_scheduler: table-driven directed bench for elevator_scheduler (4 floors, travel 4, door 3).
// Extra emergency-stop sequence is built when EMERGENCY_STOP_EN is defined.
module tb_elevator_scheduler;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    elevator_scheduler_if #(.FLOORS(4), .FLOOR_W(2)) bus();

    elevator_scheduler #(.FLOORS(4), .FLOOR_W(2), .TRAVEL_CYC(4), .DOOR_CYC(3)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        int         n;
        bit         rst;
        logic [3:0] call;
        logic [1:0] floor;
        logic [3:0] pend;
        logic       mu;
        logic       md;
        logic       door;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input bit rst, input logic [3:0] call);
        @(negedge clk);
        reset      = !rst;
        bus.i_call = call;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input int n, input bit rst, input logic [3:0] c, input logic [1:0] f,
                       input logic [3:0] p, input logic mu, input logic md, input logic door);
        vec_t r;
        r = '{n, rst, c, f, p, mu, md, door};
        tbl.push_back(r);
    endtask

    initial begin
        int steps;
        bus.i_call = '0;
`ifdef EMERGENCY_STOP_EN
        bus.i_estop = 1'b0;
`endif
        // reset, then single-floor door cycle at floor 0
        add(2, 1, 4'b0000, 0, 4'b0000, 0, 0, 0);
        add(1, 0, 4'b0001, 0, 4'b0000, 0, 0, 1);
        add(2, 0, 4'b0000, 0, 4'b0000, 0, 0, 1);
        add(2, 0, 4'b0000, 0, 4'b0000, 0, 0, 0);
        // call to top floor: hop, idle, hop, idle, hop, door
        add(1, 0, 4'b1000, 0, 4'b1000, 1, 0, 0);
        add(3, 0, 4'b0000, 0, 4'b1000, 1, 0, 0);
        add(1, 0, 4'b0000, 1, 4'b1000, 0, 0, 0);
        add(4, 0, 4'b0000, 1, 4'b1000, 1, 0, 0);
        add(1, 0, 4'b0000, 2, 4'b1000, 0, 0, 0);
        add(4, 0, 4'b0000, 2, 4'b1000, 1, 0, 0);
        add(1, 0, 4'b0000, 3, 4'b1000, 0, 0, 0);
        add(3, 0, 4'b0000, 3, 4'b0000, 0, 0, 1);
        add(1, 0, 4'b0000, 3, 4'b0000, 0, 0, 0);
        // SCAN: moving 1->2 with 1000 pending, add 0101 -> serve 2, 3, then 0
        add(1, 1, 4'b0000, 0, 4'b0000, 0, 0, 0);
        add(1, 0, 4'b1000, 0, 4'b1000, 1, 0, 0);
        add(3, 0, 4'b0000, 0, 4'b1000, 1, 0, 0);
        add(1, 0, 4'b0000, 1, 4'b1000, 0, 0, 0);
        add(1, 0, 4'b0000, 1, 4'b1000, 1, 0, 0);
        add(1, 0, 4'b0101, 1, 4'b1101, 1, 0, 0);
        add(2, 0, 4'b0000, 1, 4'b1101, 1, 0, 0);
        add(1, 0, 4'b0000, 2, 4'b1101, 0, 0, 0);
        add(3, 0, 4'b0000, 2, 4'b1001, 0, 0, 1);
        add(1, 0, 4'b0000, 2, 4'b1001, 0, 0, 0);
        add(4, 0, 4'b0000, 2, 4'b1001, 1, 0, 0);
        add(1, 0, 4'b0000, 3, 4'b1001, 0, 0, 0);
        add(3, 0, 4'b0000, 3, 4'b0001, 0, 0, 1);
        add(1, 0, 4'b0000, 3, 4'b0001, 0, 0, 0);
        add(4, 0, 4'b0000, 3, 4'b0001, 0, 1, 0);
        add(1, 0, 4'b0000, 2, 4'b0001, 0, 0, 0);
        add(4, 0, 4'b0000, 2, 4'b0001, 0, 1, 0);
        add(1, 0, 4'b0000, 1, 4'b0001, 0, 0, 0);
        add(4, 0, 4'b0000, 1, 4'b0001, 0, 1, 0);
        add(1, 0, 4'b0000, 0, 4'b0001, 0, 0, 0);
        add(3, 0, 4'b0000, 0, 4'b0000, 0, 0, 1);
        add(1, 0, 4'b0000, 0, 4'b0000, 0, 0, 0);
        // reset mid-travel at floor 2 with 1001 pending; dir_up tie-break at floor 1
        add(1, 0, 4'b1000, 0, 4'b1000, 1, 0, 0);
        add(1, 0, 4'b0001, 0, 4'b1001, 1, 0, 0);
        add(2, 0, 4'b0000, 0, 4'b1001, 1, 0, 0);
        add(1, 0, 4'b0000, 1, 4'b1001, 0, 0, 0);
        add(4, 0, 4'b0000, 1, 4'b1001, 1, 0, 0);
        add(1, 0, 4'b0000, 2, 4'b1001, 0, 0, 0);
        add(1, 0, 4'b0000, 2, 4'b1001, 1, 0, 0);
        add(1, 1, 4'b0000, 0, 4'b0000, 0, 0, 0);
        add(1, 0, 4'b0000, 0, 4'b0000, 0, 0, 0);
        // door held by same-floor call; other-floor call during door latches
        add(1, 0, 4'b0001, 0, 4'b0000, 0, 0, 1);
        add(1, 0, 4'b0000, 0, 4'b0000, 0, 0, 1);
        add(1, 0, 4'b0001, 0, 4'b0000, 0, 0, 1);
        add(1, 0, 4'b0010, 0, 4'b0010, 0, 0, 1);
        add(1, 0, 4'b0000, 0, 4'b0010, 0, 0, 1);
        add(1, 0, 4'b0000, 0, 4'b0010, 0, 0, 0);
        add(1, 0, 4'b0000, 0, 4'b0010, 1, 0, 0);

        foreach (tbl[k]) begin
            for (int j = 0; j < tbl[k].n; j++) begin
                step(tbl[k].rst, tbl[k].call);
                check($sformatf("row%0d.%0d floor", k, j), 32'(bus.o_floor), 32'(tbl[k].floor));
                check($sformatf("row%0d.%0d pending", k, j), 32'(bus.o_pending), 32'(tbl[k].pend));
                check($sformatf("row%0d.%0d motion", k, j), 32'({bus.o_moving_up, bus.o_moving_down}),
                      32'({tbl[k].mu, tbl[k].md}));
                check($sformatf("row%0d.%0d door/green/red", k, j),
                      32'({bus.o_door_open, bus.o_green, bus.o_red}),
                      32'({tbl[k].door, tbl[k].door, !tbl[k].door}));
            end
        end

        // two-floor trip latency: arrival at floor 2 on the 10th edge, door on the 11th
        step(1, 4'b0000);
        step(0, 4'b0100);
        steps = 1;
        while (bus.o_floor != 2'd2 && steps < 40) begin
            step(0, 4'b0000);
            steps++;
        end
        check("trip0to2 edges", 32'(steps), 32'd10);
        step(0, 4'b0000);
        check("trip0to2 door", 32'({bus.o_door_open, bus.o_pending}), 32'({1'b1, 4'b0000}));

`ifdef EMERGENCY_STOP_EN
        // estop for 5 edges after one travel edge delays arrival by exactly 5
        step(1, 4'b0000);
        step(0, 4'b0010);
        step(0, 4'b0000);
        @(negedge clk);
        bus.i_estop = 1'b1;
        for (int j = 0; j < 5; j++) begin
            step(0, 4'b0000);
            check($sformatf("estop%0d floor", j), 32'(bus.o_floor), 32'd0);
            check($sformatf("estop%0d red/green", j), 32'({bus.o_red, bus.o_green}), 32'({1'b1, 1'b0}));
        end
        @(negedge clk);
        bus.i_estop = 1'b0;
        steps = 0;
        while (bus.o_floor != 2'd1 && steps < 40) begin
            step(0, 4'b0000);
            steps++;
        end
        check("estop release edges", 32'(steps), 32'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
